// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
//   state_t       : top-level FSM states
//   MODE_*        : payload pattern selectors
//   LFSR_TAPS     : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next()   : one left shift of the Fibonacci LFSR
//   pattern_init(): first byte of a frame for a given seed/mode
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INCR  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6:0], ^(d & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR state would lock up, so seed 0 starts from 0x01.
    function automatic logic [7:0] pattern_init(input logic [7:0] seed, input logic [1:0] mode);
        return ((mode == MODE_LFSR) && (seed == 8'h00)) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// Payload byte generator for axis_packet_generator.
//   aclk, aresetn : clock, asynchronous active-low reset
//   load          : latch seed/mode and restart the pattern (accepted start)
//   rewind        : restart the pattern from the latched seed (frame end)
//   advance       : step the pattern (beat handshake)
//   seed, mode    : configuration sampled on load
//   data          : current payload byte
module axis_pattern_gen
    import axis_gen_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       load,
    input  logic       rewind,
    input  logic       advance,
    input  logic [7:0] seed,
    input  logic [1:0] mode,
    output logic [7:0] data
);

    logic [7:0] seed_q;
    logic [1:0] mode_q;

    // rewind has priority over advance: the last beat of a frame steps
    // straight back to the seed instead of producing one more value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seed_q <= 8'h00;
            mode_q <= MODE_INCR;
            data   <= 8'h00;
        end else if (load) begin
            seed_q <= seed;
            mode_q <= mode;
            data   <= pattern_init(seed, mode);
        end else if (rewind) begin
            data <= pattern_init(seed_q, mode_q);
        end else if (advance) begin
            case (mode_q)
                MODE_INCR:  data <= data + 8'd1;
                MODE_CONST: data <= data;
                MODE_LFSR:  data <= lfsr_next(data);
                default:    data <= ~data;
            endcase
        end
    end

endmodule

// File: rtl/axis_packet_generator.sv
// AXI4-Stream master emitting a burst of num_pkts frames of pkt_len bytes.
//   aclk, aresetn      : clock, asynchronous active-low reset
//   start              : launch a burst (sampled only in IDLE)
//   abort              : finish the current frame, then end the burst
//   pkt_len, num_pkts  : frame length and frame count, latched on start
//   mode, seed         : payload pattern selection, latched on start
//   m_axis_*           : AXI4-Stream master (tvalid/tready/tdata/tlast)
//   busy               : burst in progress (SEND or GAP)
//   done               : one-cycle pulse when the burst ends
//   pkt_count          : frames completed since the last accepted start
module axis_packet_generator
    import axis_gen_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [1:0]       mode,
    input  logic [7:0]       seed,
    input  logic             m_axis_tready,
    output logic             m_axis_tvalid,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [CNT_W-1:0] num_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             abort_q;
    logic             accept;
    logic             handshake;
    logic             last_beat;
    logic             stop;

    assign accept    = (state == IDLE) && start;
    assign handshake = m_axis_tvalid && m_axis_tready;
    assign last_beat = handshake && m_axis_tlast;
    // abort is remembered so a short pulse mid-frame still ends the burst.
    assign stop      = ((pkt_count + CNT_W'(1)) == num_q) || abort || abort_q;

    axis_pattern_gen u_pattern (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (accept),
        .rewind  (last_beat),
        .advance (handshake),
        .seed    (seed),
        .mode    (mode),
        .data    (m_axis_tdata)
    );

    // tlast is registered one beat ahead: it is set when beat_cnt is about
    // to reach len_q-1, so it stays stable through any stall on that beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_count     <= '0;
            len_q         <= '0;
            num_q         <= '0;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            abort_q       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= pkt_len;
                        num_q     <= num_pkts;
                        pkt_count <= '0;
                        beat_cnt  <= '0;
                        abort_q   <= 1'b0;
                        if ((pkt_len != '0) && (num_pkts != '0)) begin
                            state         <= SEND;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (pkt_len == LEN_W'(1));
                            busy          <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (abort) abort_q <= 1'b1;
                    if (handshake) begin
                        if (m_axis_tlast) begin
                            beat_cnt  <= '0;
                            pkt_count <= pkt_count + CNT_W'(1);
                            if (stop) begin
                                state         <= FIN;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                            end else if (GAP_CYCLES > 0) begin
                                state         <= GAP;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                gap_cnt       <= '0;
                            end else begin
                                m_axis_tlast <= (len_q == LEN_W'(1));
                            end
                        end else begin
                            beat_cnt     <= beat_cnt + LEN_W'(1);
                            m_axis_tlast <= ((beat_cnt + LEN_W'(2)) == len_q);
                        end
                    end
                end
                GAP: begin
                    if (abort || abort_q) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        state         <= SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (len_q == LEN_W'(1));
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_generator.sv
// Directed testbench for axis_packet_generator. Two instances share the
// configuration inputs: u_dut (no inter-frame gap) and u_gap (2-cycle gap).
module tb_axis_packet_generator;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        start_g;
    logic        abort;
    logic [7:0]  pkt_len;
    logic [15:0] num_pkts;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic        tready;

    logic        tvalid,   tlast,   busy,   done;
    logic [7:0]  tdata;
    logic [15:0] pkt_count;
    logic        tvalid_g, tlast_g, busy_g, done_g;
    logic [7:0]  tdata_g;
    logic [15:0] pkt_count_g;

    int n_checks = 0;
    int n_fail   = 0;

    logic       vld_tr [$];
    logic [7:0] dat_tr [$];
    logic       lst_tr [$];
    logic       rdy_tr [$];
    logic       done_tr[$];
    logic       busy_tr[$];

    axis_packet_generator u_dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .pkt_len(pkt_len), .num_pkts(num_pkts), .mode(mode), .seed(seed),
        .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
        .m_axis_tlast(tlast), .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    axis_packet_generator #(.GAP_CYCLES(2)) u_gap (
        .aclk(aclk), .aresetn(aresetn), .start(start_g), .abort(abort),
        .pkt_len(pkt_len), .num_pkts(num_pkts), .mode(mode), .seed(seed),
        .m_axis_tready(tready), .m_axis_tvalid(tvalid_g), .m_axis_tdata(tdata_g),
        .m_axis_tlast(tlast_g), .busy(busy_g), .done(done_g), .pkt_count(pkt_count_g)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic do_start(input bit sel_g);
        if (sel_g) start_g = 1'b1;
        else       start   = 1'b1;
        @(posedge aclk); #1;
        start   = 1'b0;
        start_g = 1'b0;
    endtask

    // Records n cycles of outputs at the falling edge; abort/start are
    // asserted during the cycle whose index matches abort_at/start_at.
    task automatic capture(input int n, input bit sel_g, input bit toggle,
                           input int abort_at, input int start_at);
        vld_tr.delete(); dat_tr.delete(); lst_tr.delete();
        rdy_tr.delete(); done_tr.delete(); busy_tr.delete();
        abort   = (abort_at == 0);
        start   = !sel_g && (start_at == 0);
        start_g = sel_g && (start_at == 0);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            vld_tr.push_back(sel_g ? tvalid_g : tvalid);
            dat_tr.push_back(sel_g ? tdata_g  : tdata);
            lst_tr.push_back(sel_g ? tlast_g  : tlast);
            done_tr.push_back(sel_g ? done_g  : done);
            busy_tr.push_back(sel_g ? busy_g  : busy);
            rdy_tr.push_back(tready);
            @(posedge aclk); #1;
            if (toggle) tready = ~tready;
            abort   = (i + 1 == abort_at);
            start   = !sel_g && (i + 1 == start_at);
            start_g = sel_g && (i + 1 == start_at);
        end
        abort   = 1'b0;
        start   = 1'b0;
        start_g = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if ({tvalid, tdata, tlast, busy, done, pkt_count} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_dut: got v=%b d=%h l=%b busy=%b done=%b cnt=%0d, want all 0",
                     tvalid, tdata, tlast, busy, done, pkt_count);
        end
        n_checks++;
        if ({tvalid_g, tdata_g, tlast_g, busy_g, done_g, pkt_count_g} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_gap: got v=%b d=%h l=%b busy=%b done=%b cnt=%0d, want all 0",
                     tvalid_g, tdata_g, tlast_g, busy_g, done_g, pkt_count_g);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_incr();
        logic [7:0] exp_d [8];
        logic ev, el, edn, eb;
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h01};
        pkt_len = 8'd4; num_pkts = 16'd2; mode = 2'd0; seed = 8'hFE; tready = 1'b1;
        do_start(1'b0);
        capture(12, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 12; i++) begin
            ev = (i < 8); el = (i == 3 || i == 7); edn = (i == 8); eb = (i < 8);
            n_checks++;
            if (vld_tr[i] !== ev || lst_tr[i] !== el || done_tr[i] !== edn ||
                busy_tr[i] !== eb || (ev && dat_tr[i] !== exp_d[i % 8])) begin
                n_fail++;
                $display("FAIL incr_cycle%0d: got v=%b d=%h l=%b done=%b busy=%b, want v=%b d=%h l=%b done=%b busy=%b",
                         i, vld_tr[i], dat_tr[i], lst_tr[i], done_tr[i], busy_tr[i],
                         ev, exp_d[i % 8], el, edn, eb);
            end
        end
        n_checks++;
        if (pkt_count !== 16'd2) begin
            n_fail++;
            $display("FAIL incr_pkt_count: got %0d, want 2", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        logic ev, el, edn;
        pkt_len = 8'd3; num_pkts = 16'd1; mode = 2'd1; seed = 8'h5A; tready = 1'b1;
        do_start(1'b0);
        capture(10, 1'b0, 1'b1, -1, -1);
        for (int i = 0; i < 10; i++) begin
            ev = (i < 5); el = (i == 3 || i == 4); edn = (i == 5);
            n_checks++;
            if (vld_tr[i] !== ev || lst_tr[i] !== el || done_tr[i] !== edn ||
                (ev && dat_tr[i] !== 8'h5A)) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got v=%b d=%h l=%b done=%b, want v=%b d=5a l=%b done=%b",
                         i, vld_tr[i], dat_tr[i], lst_tr[i], done_tr[i], ev, el, edn);
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (vld_tr[i] && !rdy_tr[i]) begin
                n_checks++;
                if (vld_tr[i+1] !== 1'b1 || dat_tr[i+1] !== dat_tr[i] || lst_tr[i+1] !== lst_tr[i]) begin
                    n_fail++;
                    $display("FAIL stall_hold%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             i + 1, vld_tr[i+1], dat_tr[i+1], lst_tr[i+1], dat_tr[i], lst_tr[i]);
                end
            end
        end
        n_checks++;
        if (pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_pkt_count: got %0d, want 1", pkt_count);
        end
        tready = 1'b1;
    endtask

    task automatic test_gap();
        logic ev_t [12];
        logic [7:0] ed;
        logic el, edn;
        ev_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        pkt_len = 8'd2; num_pkts = 16'd3; mode = 2'd3; seed = 8'h0F; tready = 1'b1;
        do_start(1'b1);
        capture(12, 1'b1, 1'b0, -1, -1);
        for (int i = 0; i < 12; i++) begin
            ed  = (i % 2 == 0) ? 8'h0F : 8'hF0;
            el  = ev_t[i] && (i % 2 == 1);
            edn = (i == 10);
            n_checks++;
            if (vld_tr[i] !== ev_t[i] || lst_tr[i] !== el || done_tr[i] !== edn ||
                (ev_t[i] && dat_tr[i] !== ed)) begin
                n_fail++;
                $display("FAIL gap_cycle%0d: got v=%b d=%h l=%b done=%b, want v=%b d=%h l=%b done=%b",
                         i, vld_tr[i], dat_tr[i], lst_tr[i], done_tr[i], ev_t[i], ed, el, edn);
            end
        end
        n_checks++;
        if (pkt_count_g !== 16'd3) begin
            n_fail++;
            $display("FAIL gap_pkt_count: got %0d, want 3", pkt_count_g);
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_d [5];
        logic ev, el, edn;
        exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        pkt_len = 8'd5; num_pkts = 16'd10; mode = 2'd2; seed = 8'h00; tready = 1'b1;
        do_start(1'b0);
        capture(12, 1'b0, 1'b0, 1, -1);
        for (int i = 0; i < 12; i++) begin
            ev = (i < 5); el = (i == 4); edn = (i == 5);
            n_checks++;
            if (vld_tr[i] !== ev || lst_tr[i] !== el || done_tr[i] !== edn ||
                (ev && dat_tr[i] !== exp_d[i % 5])) begin
                n_fail++;
                $display("FAIL abort_cycle%0d: got v=%b d=%h l=%b done=%b, want v=%b d=%h l=%b done=%b",
                         i, vld_tr[i], dat_tr[i], lst_tr[i], done_tr[i], ev, exp_d[i % 5], el, edn);
            end
        end
        n_checks++;
        if (pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL abort_pkt_count: got %0d, want 1", pkt_count);
        end
    endtask

    task automatic test_empty();
        logic [7:0]  lens [2];
        logic [15:0] nums [2];
        lens = '{8'd0, 8'd4};
        nums = '{16'd3, 16'd0};
        for (int k = 0; k < 2; k++) begin
            pkt_len = lens[k]; num_pkts = nums[k]; mode = 2'd0; seed = 8'h12; tready = 1'b1;
            do_start(1'b0);
            capture(4, 1'b0, 1'b0, -1, -1);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (vld_tr[i] !== 1'b0 || busy_tr[i] !== 1'b0 || done_tr[i] !== (i == 0)) begin
                    n_fail++;
                    $display("FAIL empty%0d_cycle%0d: got v=%b busy=%b done=%b, want v=0 busy=0 done=%b",
                             k, i, vld_tr[i], busy_tr[i], done_tr[i], (i == 0));
                end
            end
            n_checks++;
            if (pkt_count !== 16'd0) begin
                n_fail++;
                $display("FAIL empty%0d_pkt_count: got %0d, want 0", k, pkt_count);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic ev, el, edn, eb;
        logic [7:0] ed;
        pkt_len = 8'd4; num_pkts = 16'd1; mode = 2'd0; seed = 8'h10; tready = 1'b1;
        do_start(1'b0);
        pkt_len = 8'd2; num_pkts = 16'd5; mode = 2'd1; seed = 8'h33;
        capture(8, 1'b0, 1'b0, -1, 2);
        for (int i = 0; i < 8; i++) begin
            ev = (i < 4); el = (i == 3); edn = (i == 4); eb = (i < 4);
            ed = 8'h10 + 8'(i);
            n_checks++;
            if (vld_tr[i] !== ev || lst_tr[i] !== el || done_tr[i] !== edn ||
                busy_tr[i] !== eb || (ev && dat_tr[i] !== ed)) begin
                n_fail++;
                $display("FAIL busy_start_cycle%0d: got v=%b d=%h l=%b done=%b busy=%b, want v=%b d=%h l=%b done=%b busy=%b",
                         i, vld_tr[i], dat_tr[i], lst_tr[i], done_tr[i], busy_tr[i], ev, ed, el, edn, eb);
            end
        end
        n_checks++;
        if (pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL busy_start_pkt_count: got %0d, want 1", pkt_count);
        end
    endtask

    task automatic test_reset_midframe();
        pkt_len = 8'd4; num_pkts = 16'd2; mode = 2'd0; seed = 8'hA0; tready = 1'b0;
        do_start(1'b0);
        repeat (2) begin
            @(negedge aclk);
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== 8'hA0 || tlast !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL midframe_stall: got v=%b d=%h l=%b busy=%b, want v=1 d=a0 l=0 busy=1",
                         tvalid, tdata, tlast, busy);
            end
        end
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({tvalid, tdata, tlast, busy, done, pkt_count} !== 28'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got v=%b d=%h l=%b busy=%b done=%b cnt=%0d, want all 0",
                     tvalid, tdata, tlast, busy, done, pkt_count);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        pkt_len = 8'd2; num_pkts = 16'd1; mode = 2'd1; seed = 8'h77; tready = 1'b1;
        do_start(1'b0);
        capture(5, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (vld_tr[i] !== (i < 2) || lst_tr[i] !== (i == 1) || done_tr[i] !== (i == 2) ||
                ((i < 2) && dat_tr[i] !== 8'h77)) begin
                n_fail++;
                $display("FAIL after_reset_cycle%0d: got v=%b d=%h l=%b done=%b, want v=%b d=77 l=%b done=%b",
                         i, vld_tr[i], dat_tr[i], lst_tr[i], done_tr[i], (i < 2), (i == 1), (i == 2));
            end
        end
        n_checks++;
        if (pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL after_reset_pkt_count: got %0d, want 1", pkt_count);
        end
    endtask

    initial begin
        start = 1'b0; start_g = 1'b0; abort = 1'b0; tready = 1'b1;
        pkt_len = 8'd0; num_pkts = 16'd0; mode = 2'd0; seed = 8'd0;
        test_reset();
        test_incr();
        test_backpressure();
        test_gap();
        test_abort();
        test_empty();
        test_start_while_busy();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
